// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared fixed-point types and constants for the PPU datapath
package ppu_pkg;

    // Default fixed-point format: FX_M integer bits inside an FX_B-bit word
    localparam int PPU_FX_M = 16;
    localparam int PPU_FX_B = 64;

    // Most positive / most negative values of the default format
    localparam logic [PPU_FX_B-1:0] FX_MAX = {1'b0, {(PPU_FX_B-1){1'b1}}};
    localparam logic [PPU_FX_B-1:0] FX_MIN = {1'b1, {(PPU_FX_B-1){1'b0}}};

    // Quire commands, one per accepted handshake
    typedef enum logic [1:0] {
        QCMD_NOP   = 2'd0,
        QCMD_INIT  = 2'd1,
        QCMD_ACC   = 2'd2,
        QCMD_DRAIN = 2'd3
    } quire_cmd_e;

    // Integer bits must leave room for the sign inside the word
    function automatic bit fx_cfg_ok(input int m, input int b);
        return (m >= 1) && (m < b);
    endfunction

endpackage

// File: rtl/fma_quire_bank_fixed_sat_add.sv
// rtl/fma_quire_bank_fixed_sat_add.sv - two's complement adder with optional saturation
module fixed_sat_add #(
    parameter int FX_B     = 64,
    parameter int SATURATE = 1
) (
    input  logic [FX_B-1:0] a_i,
    input  logic [FX_B-1:0] b_i,
    output logic [FX_B-1:0] sum_o,
    output logic            ovf_o
);

    logic [FX_B-1:0] w_sum;
    logic [FX_B-1:0] w_max;
    logic [FX_B-1:0] w_min;

    assign w_max = {1'b0, {(FX_B-1){1'b1}}};
    assign w_min = {1'b1, {(FX_B-1){1'b0}}};

    // Overflow when both operands share a sign the raw sum does not have
    always_comb begin
        w_sum = a_i + b_i;
        ovf_o = (a_i[FX_B-1] == b_i[FX_B-1]) && (w_sum[FX_B-1] != a_i[FX_B-1]);
        sum_o = w_sum;
        if ((SATURATE != 0) && ovf_o) begin
            sum_o = a_i[FX_B-1] ? w_min : w_max;
        end
    end

endmodule

// File: rtl/fma_quire_bank.sv
// rtl/fma_quire_bank.sv - multi-channel fixed-point quire accumulator bank
module fma_quire_bank
    import ppu_pkg::*;
#(
    parameter int FX_M     = PPU_FX_M,
    parameter int FX_B     = PPU_FX_B,
    parameter int N_CH     = 4,
    parameter int CNT_W    = 8,
    parameter int SATURATE = 1,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  quire_cmd_e       cmd_i,
    input  logic [CH_W-1:0]  ch_i,
    input  logic [FX_B-1:0]  operand_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [FX_B-1:0]  out_fixed_o,
    output logic [CH_W-1:0]  out_ch_o,
    output logic [CNT_W-1:0] out_cnt_o,
    output logic             out_ovf_o,
    output logic             err_o
);

    if (!fx_cfg_ok(FX_M, FX_B) || (N_CH < 1)) begin : g_bad_cfg
        $error("fma_quire_bank: illegal FX_M/FX_B/N_CH combination");
    end

    // Per-channel quire state
    logic [FX_B-1:0]  r_acc [N_CH];
    logic [CNT_W-1:0] r_cnt [N_CH];
    logic             r_ovf [N_CH];

    // Drained-result register
    logic             r_out_valid;
    logic [FX_B-1:0]  r_out_fixed;
    logic [CH_W-1:0]  r_out_ch;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_out_ovf;
    logic             r_err;

    logic             w_accept;
    logic             w_ch_ok;
    logic             w_do;
    logic [CH_W-1:0]  w_ch_idx;
    logic [FX_B-1:0]  w_acc_cur;
    logic [CNT_W-1:0] w_cnt_cur;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_ovf_cur;
    logic [FX_B-1:0]  w_sum;
    logic             w_add_ovf;

    // All commands share one gate so the output register is never overrun
    assign in_ready_o = !r_out_valid || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o;

    // Out-of-range channels are swallowed; index 0 keeps the array read in bounds
    always_comb begin
        w_ch_ok    = (int'(ch_i) < N_CH);
        w_do       = w_accept && w_ch_ok;
        w_ch_idx   = w_ch_ok ? ch_i : '0;
        w_acc_cur  = r_acc[w_ch_idx];
        w_cnt_cur  = r_cnt[w_ch_idx];
        w_ovf_cur  = r_ovf[w_ch_idx];
        w_cnt_next = (&w_cnt_cur) ? w_cnt_cur : w_cnt_cur + CNT_W'(1);
    end

    // One adder serves ACC and DRAIN since only one command lands per cycle
    fixed_sat_add #(
        .FX_B     (FX_B),
        .SATURATE (SATURATE)
    ) u_add (
        .a_i   (w_acc_cur),
        .b_i   (operand_i),
        .sum_o (w_sum),
        .ovf_o (w_add_ovf)
    );

    // Channel state update; a DRAIN clears the channel on the same edge it is read
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
                r_ovf[i] <= 1'b0;
            end
        end else if (w_do) begin
            case (cmd_i)
                QCMD_INIT: begin
                    r_acc[w_ch_idx] <= operand_i;
                    r_cnt[w_ch_idx] <= CNT_W'(1);
                    r_ovf[w_ch_idx] <= 1'b0;
                end
                QCMD_ACC: begin
                    r_acc[w_ch_idx] <= w_sum;
                    r_cnt[w_ch_idx] <= w_cnt_next;
                    r_ovf[w_ch_idx] <= w_ovf_cur || w_add_ovf;
                end
                QCMD_DRAIN: begin
                    r_acc[w_ch_idx] <= '0;
                    r_cnt[w_ch_idx] <= '0;
                    r_ovf[w_ch_idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Output register: reload on DRAIN, else drop valid once consumed
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_out_valid <= 1'b0;
            r_out_fixed <= '0;
            r_out_ch    <= '0;
            r_out_cnt   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_do && (cmd_i == QCMD_DRAIN)) begin
            r_out_valid <= 1'b1;
            r_out_fixed <= w_sum;
            r_out_ch    <= w_ch_idx;
            r_out_cnt   <= w_cnt_next;
            r_out_ovf   <= w_ovf_cur || w_add_ovf;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    // Single-cycle error pulse for a consumed command aimed at a missing channel
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_ch_ok;
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_fixed_o = r_out_fixed;
    assign out_ch_o    = r_out_ch;
    assign out_cnt_o   = r_out_cnt;
    assign out_ovf_o   = r_out_ovf;
    assign err_o       = r_err;

endmodule

// File: doc/fma_quire_bank.md
Name: fma_quire_bank

Overview:
- Multi-channel fixed-point quire accumulator for the fused multiply-add path.
- Generalises the single-accumulator FMA stage to N_CH independent accumulators.
- Uses explicit per-op commands instead of inferring start/end from op transitions.
- Adds valid/ready handshakes, signed saturation, sticky overflow and a per-channel term counter.
- Sits between the fir_to_fixed converters and fixed_to_fir; consumes already-converted FX_B-bit operands.

Parameters:
- FX_M, `FX_M, integer bits of the fixed-point format (informational; passed through to package checks).
- FX_B, `FX_B, total fixed-point width (two's complement).
- N_CH, 4, number of independent accumulator channels (≥1).
- CNT_W, 8, width of the per-channel accumulated-term counter.
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-low reset
- in_valid_i  in  1  command valid
- in_ready_o  out  1  command accepted when in_valid_i & in_ready_o
- cmd_i  in  quire_cmd_e (2)  QCMD_INIT / QCMD_ACC / QCMD_DRAIN / QCMD_NOP
- ch_i  in  CH_W=max(1,$clog2(N_CH))  target channel
- operand_i  in  FX_B  signed fixed-point operand (product or init value)
- out_valid_o  out  1  drained result valid
- out_ready_i  in  1  downstream accepts result
- out_fixed_o  out  FX_B  drained accumulator value
- out_ch_o  out  CH_W  channel of drained result
- out_cnt_o  out  CNT_W  number of terms accumulated
- out_ovf_o  out  1  overflow occurred during this accumulation
- err_o  out  1  one-cycle pulse: accepted command with ch_i ≥ N_CH

Behaviour:
- Reset (rst_i=0 at posedge): all acc, cnt and ovf cleared to 0; out_valid_o=0; out_fixed_o, out_ch_o, out_cnt_o, out_ovf_o = 0; err_o=0. Reset mid-operation discards everything, including a pending output.
- in_ready_o = !out_valid_o | out_ready_i. It is combinational; only a DRAIN can fill the output register, but all commands are gated identically for simplicity.
- Accepted INIT: acc[ch] ← operand_i; cnt[ch] ← 1; ovf[ch] ← 0. Visible next cycle.
- Accepted ACC: acc[ch] ← sat_add(acc[ch], operand_i); cnt[ch] ← cnt+1, saturating at all-ones; ovf[ch] |= add overflow.
- Accepted DRAIN: computes final = sat_add(acc[ch], operand_i), counting the operand as a term.
  - Output register loads final, ch, cnt+1 (saturating) and ovf|add overflow; out_valid_o ← 1 the next cycle (latency 1).
  - The channel is cleared (acc, cnt, ovf ← 0) in the same edge.
- NOP: no state change.
- Add overflow: operand signs equal and sum sign differs.
  - SATURATE=1 → result clamps to 0x7FF…F (positive) or 0x800…0 (negative).
  - SATURATE=0 → wrapped sum.
  - Either way the sticky ovf bit is set.
- Back-to-back commands to the same channel every cycle are legal; there is no hazard, since each update completes in one cycle.
- Output register: holds its value while out_valid_o & !out_ready_i. If it is consumed and a new DRAIN is accepted in the same cycle, it reloads with out_valid_o staying 1.
- ch_i ≥ N_CH (non-power-of-two N_CH): the command is consumed with no state change and err_o pulses for 1 cycle.
- Channels are fully independent; a DRAIN on one channel never alters another.

Decomposition:
- ppu_pkg gains:
  - quire_cmd_e (2-bit enum: QCMD_NOP=0, QCMD_INIT=1, QCMD_ACC=2, QCMD_DRAIN=3).
  - Constants FX_MAX/FX_MIN derived from FX_B.
- One combinational sub-module, fixed_sat_add:
  - Parameters FX_B, SATURATE.
  - Ports a_i, b_i → sum_o, ovf_o.
  - A single instance is shared, since only one command is accepted per cycle.
- Storage is plain register arrays; no memory macro.

Test Plan:
- FX_B=64, N_CH=4: INIT ch2=0x10, ACC ch2 with 0x20 then 0x30, DRAIN ch2 with 0x5 → next cycle out_valid=1, fixed=0x65, ch=2, cnt=4, ovf=0; ch2 reads 0 afterwards.
- Interleave ACC on ch0 and ch1 every cycle (ch0 += 1 ×10, ch1 += −2 ×10), then DRAIN both with 0 → results 10 then −20 (0xFFFF…FFEC), cnt=11 each.
- INIT ch1=FX_MAX, ACC ch1 with 1, DRAIN with 0 → SATURATE=1: fixed=0x7FFF…FFFF, ovf=1; rerun with SATURATE=0 → fixed=0x8000…0000, ovf=1.
- DRAIN ch0 with out_ready_i=0 held 3 cycles while in_valid_i asserts DRAIN ch3 → in_ready_o=0, output holds ch0 value. When out_ready_i rises: ch3 accepted, ch0 consumed and output reloads in the same cycle with no bubble.
- N_CH=3: ACC with ch_i=3 → err_o single-cycle pulse; all channels unchanged; in_ready_o stays 1.
- Assert rst_i=0 with a pending unconsumed output and non-zero accumulators → next cycle out_valid_o=0 and all channels drain as 0 with cnt=1.
